// File: rtl/isp_prim_fetch.sv
// ISP primitive-set fetcher: walks a strip, triangle array or quad array from VRAM
// and streams tagged header/vertex words to the rasteriser.
module isp_prim_fetch #(
  parameter int ADDR_W     = 24,
  parameter int DATA_W     = 32,
  parameter int MAX_VWORDS = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [31:0]       opb_word,
  input  logic [ADDR_W-1:0] poly_addr,
  input  logic              render_poly,
  output logic              vram_rd,
  output logic [ADDR_W-1:0] vram_addr,
  input  logic              vram_ack,
  input  logic [DATA_W-1:0] vram_din,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_hdr,
  output logic [1:0]        out_vert,
  output logic [3:0]        out_widx,
  output logic              out_first,
  output logic              out_last,
  output logic              busy,
  output logic              poly_done
);

  typedef enum logic [2:0] {IDLE, HDR_RD, HDR_RP, VTX_RD, FLUSH, DONE} state_t;

  localparam logic [4:0] VW_MAX = 5'(MAX_VWORDS);

  state_t state, nxt;

  logic [ADDR_W-1:0] base_addr, rd_addr;
  logic [2:0]        hw;
  logic [4:0]        vw;
  logic [1:0]        nv_m1;
  logic              strip;
  logic [2:0]        cur_k;
  logic [5:0]        mask_rem;
  logic [3:0]        prim_left;
  logic [3:0]        widx;
  logic [1:0]        vidx;
  logic              pending;
  logic [DATA_W-1:0] hdr_regs [5];

  logic              is_strip_in, is_tri_in, is_quad_in;
  logic [5:0]        mask_in;
  logic [2:0]        hw_in;
  logic [4:0]        vw_raw, vw_in;
  logic [ADDR_W-1:0] addr_in;
  logic              slot_free, got, rp_go, hdr_end, vtx_end, prim_end, more;
  logic [2:0]        first_k, next_k;
  logic              unused_bits;

  function automatic logic [2:0] lowest(input logic [5:0] m);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 5; i >= 0; i--)
      if (m[i]) r = 3'(i);
    return r;
  endfunction

  function automatic logic [ADDR_W-1:0] vtx_addr(input logic [ADDR_W-1:0] b,
                                                 input logic [2:0] h,
                                                 input logic [4:0] v,
                                                 input logic [2:0] k);
    logic [ADDR_W-1:0] words;
    words = ADDR_W'(h) + ADDR_W'(v) * ADDR_W'(k);
    return b + (words << 2);
  endfunction

  // Strip triangle k is enabled by opb_word[30-k]; bit 0 of the mask is triangle 0.
  assign is_strip_in = ~opb_word[31];
  assign is_tri_in   = (opb_word[31:29] == 3'b100);
  assign is_quad_in  = (opb_word[31:29] == 3'b101);
  assign mask_in     = {opb_word[25], opb_word[26], opb_word[27],
                        opb_word[28], opb_word[29], opb_word[30]};
  assign hw_in       = opb_word[24] ? 3'd5 : 3'd3;
  assign vw_raw      = 5'd3 + (opb_word[24] ? {1'b0, opb_word[23:21], 1'b0}
                                            : {2'b00, opb_word[23:21]});
  assign vw_in       = (vw_raw > VW_MAX) ? VW_MAX : vw_raw;
  assign addr_in     = {poly_addr[ADDR_W-1:2], 2'b00};
  assign first_k     = lowest(mask_in);
  assign next_k      = lowest(mask_rem);
  assign unused_bits = ^{opb_word[20:0], poly_addr[1:0]};

  // A request is only opened when the output slot is empty or draining, so the
  // acked word always has somewhere to land.
  assign slot_free = ~out_valid | out_ready;
  assign got       = vram_rd & vram_ack;
  assign rp_go     = (state == HDR_RP) & slot_free;
  assign hdr_end   = (widx == 4'(hw) - 4'd1);
  assign vtx_end   = ({1'b0, widx} == vw - 5'd1);
  assign prim_end  = (state == VTX_RD) & vtx_end & (vidx == nv_m1);
  assign more      = strip ? (mask_rem != 6'd0) : (prim_left != 4'd0);
  assign vram_addr = rd_addr;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= nxt;
  end

  always_comb begin
    nxt       = state;
    vram_rd   = 1'b0;
    busy      = 1'b0;
    poly_done = 1'b0;
    case (state)
      IDLE: begin
        if (render_poly) begin
          if (is_tri_in || is_quad_in || (is_strip_in && mask_in != 6'd0)) nxt = HDR_RD;
          else                                                             nxt = DONE;
        end
      end
      HDR_RD: begin
        busy    = 1'b1;
        vram_rd = pending | slot_free;
        if (vram_rd && vram_ack && hdr_end) nxt = VTX_RD;
      end
      HDR_RP: begin
        busy = 1'b1;
        if (slot_free && hdr_end) nxt = VTX_RD;
      end
      VTX_RD: begin
        busy    = 1'b1;
        vram_rd = pending | slot_free;
        if (vram_rd && vram_ack && vtx_end && vidx == nv_m1) begin
          if (!more)     nxt = FLUSH;
          else if (strip) nxt = HDR_RP;
          else           nxt = HDR_RD;
        end
      end
      FLUSH: begin
        busy = 1'b1;
        if (slot_free) nxt = DONE;
      end
      DONE: begin
        poly_done = 1'b1;
        nxt       = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      base_addr <= '0;
      rd_addr   <= '0;
      hw        <= '0;
      vw        <= '0;
      nv_m1     <= '0;
      strip     <= 1'b0;
      cur_k     <= '0;
      mask_rem  <= '0;
      prim_left <= '0;
      widx      <= '0;
      vidx      <= '0;
      pending   <= 1'b0;
      for (int i = 0; i < 5; i++) hdr_regs[i] <= '0;
    end else begin
      pending <= vram_rd & ~vram_ack;
      if (state == IDLE && render_poly) begin
        base_addr <= addr_in;
        rd_addr   <= addr_in;
        hw        <= hw_in;
        vw        <= vw_in;
        nv_m1     <= is_quad_in ? 2'd3 : 2'd2;
        strip     <= is_strip_in;
        cur_k     <= first_k;
        mask_rem  <= mask_in & ~(6'b1 << first_k);
        prim_left <= opb_word[28:25];
        widx      <= '0;
        vidx      <= '0;
      end
      if (got && state == HDR_RD) hdr_regs[widx[2:0]] <= vram_din;
      if (got || rp_go) begin
        if (state == VTX_RD) begin
          if (vtx_end) begin
            widx <= '0;
            vidx <= (vidx == nv_m1) ? 2'd0 : vidx + 2'd1;
          end else begin
            widx <= widx + 4'd1;
          end
        end else begin
          widx <= hdr_end ? 4'd0 : widx + 4'd1;
        end
      end
      // Strips jump to their first vertex; arrays are one contiguous run of words.
      if (got) begin
        if (state == HDR_RD && hdr_end && strip) rd_addr <= vtx_addr(base_addr, hw, vw, cur_k);
        else if (prim_end && strip)             rd_addr <= vtx_addr(base_addr, hw, vw, next_k);
        else                                     rd_addr <= rd_addr + ADDR_W'(4);
      end
      if (got && prim_end && strip) begin
        cur_k    <= next_k;
        mask_rem <= mask_rem & ~(6'b1 << next_k);
      end
      if (got && prim_end && !strip) prim_left <= prim_left - 4'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_hdr   <= 1'b0;
      out_vert  <= '0;
      out_widx  <= '0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
    end else if (got || rp_go) begin
      out_valid <= 1'b1;
      out_data  <= got ? vram_din : hdr_regs[widx[2:0]];
      out_hdr   <= (state != VTX_RD);
      out_vert  <= (state == VTX_RD) ? vidx : 2'd0;
      out_widx  <= widx;
      out_first <= (state != VTX_RD) && (widx == 4'd0);
      out_last  <= prim_end;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_isp_prim_fetch.sv
// Self-checking bench for isp_prim_fetch: a spec-level model builds the expected read
// addresses and stream words, and one monitor compares the DUT against it every cycle.
module tb_isp_prim_fetch;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] opb_word;
  logic [23:0] poly_addr;
  logic        render_poly;
  logic        vram_rd;
  logic [23:0] vram_addr;
  logic        vram_ack;
  logic [31:0] vram_din;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_hdr;
  logic [1:0]  out_vert;
  logic [3:0]  out_widx;
  logic        out_first;
  logic        out_last;
  logic        busy;
  logic        poly_done;

  isp_prim_fetch dut (
    .clock(clock), .reset_n(reset_n), .opb_word(opb_word), .poly_addr(poly_addr),
    .render_poly(render_poly), .vram_rd(vram_rd), .vram_addr(vram_addr),
    .vram_ack(vram_ack), .vram_din(vram_din), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_hdr(out_hdr),
    .out_vert(out_vert), .out_widx(out_widx), .out_first(out_first),
    .out_last(out_last), .busy(busy), .poly_done(poly_done)
  );

  always #5 clock = ~clock;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [40:0] exp_out[$];
  logic [23:0] exp_rd[$];
  int          rd_count, word_count, done_count;
  bit          mon_en = 1'b0;
  bit          rand_mode = 1'b0;

  function automatic logic [31:0] mem_word(input logic [23:0] a);
    return {a[15:8], a} ^ 32'h5AC3_0F96;
  endfunction

  function automatic logic [40:0] pk(input bit h, input logic [1:0] v, input logic [3:0] w,
                                     input bit f, input bit l, input logic [31:0] d);
    return {h, v, w, f, l, d};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Expected reads and stream words straight from the addressing rules.
  task automatic buildModel(input logic [31:0] opb, input logic [23:0] pa);
    int  hw, vw, n, cnt, a, b;
    bit  hdr_seen;
    exp_rd.delete();
    exp_out.delete();
    hw = opb[24] ? 5 : 3;
    vw = 3 + int'(opb[23:21]) * (opb[24] ? 2 : 1);
    if (vw > 16) vw = 16;
    hdr_seen = 1'b0;
    if (!opb[31]) begin
      for (int k = 0; k < 6; k++) begin
        if (opb[30-k]) begin
          for (int h = 0; h < hw; h++) begin
            a = int'(pa) + 4*h;
            if (!hdr_seen) exp_rd.push_back(24'(a));
            exp_out.push_back(pk(1'b1, 2'd0, 4'(h), h == 0, 1'b0, mem_word(24'(a))));
          end
          hdr_seen = 1'b1;
          for (int i = 0; i < 3; i++)
            for (int w = 0; w < vw; w++) begin
              a = int'(pa) + 4*(hw + vw*(k+i)) + 4*w;
              exp_rd.push_back(24'(a));
              exp_out.push_back(pk(1'b0, 2'(i), 4'(w), 1'b0, (i == 2) && (w == vw-1), mem_word(24'(a))));
            end
        end
      end
    end else if (!opb[30]) begin
      n   = opb[29] ? 4 : 3;
      cnt = int'(opb[28:25]) + 1;
      for (int p = 0; p < cnt; p++) begin
        b = int'(pa) + 4*p*(hw + n*vw);
        for (int h = 0; h < hw; h++) begin
          a = b + 4*h;
          exp_rd.push_back(24'(a));
          exp_out.push_back(pk(1'b1, 2'd0, 4'(h), h == 0, 1'b0, mem_word(24'(a))));
        end
        for (int v = 0; v < n; v++)
          for (int w = 0; w < vw; w++) begin
            a = b + 4*(hw + vw*v + w);
            exp_rd.push_back(24'(a));
            exp_out.push_back(pk(1'b0, 2'(v), 4'(w), 1'b0, (v == n-1) && (w == vw-1), mem_word(24'(a))));
          end
      end
    end
  endtask

  // VRAM responder, ready driver and the single compare process.
  initial begin : monitor
    int          wait_left;
    bit          in_wait, prev_rd_wait, prev_stall;
    logic [23:0] prev_addr;
    logic [40:0] prev_pack, now_pack, e;
    vram_ack = 1'b0; vram_din = '0; out_ready = 1'b1;
    in_wait = 0; prev_rd_wait = 0; prev_stall = 0; wait_left = 0;
    prev_addr = '0; prev_pack = '0;
    forever begin
      @(negedge clock);
      out_ready = rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
      #1;
      if (vram_rd) begin
        if (!in_wait) begin
          wait_left = rand_mode ? int'($urandom_range(0, 5)) : 0;
          in_wait   = 1'b1;
        end
        if (wait_left == 0) begin
          vram_ack = 1'b1; vram_din = mem_word(vram_addr); in_wait = 1'b0;
        end else begin
          vram_ack = 1'b0; wait_left--;
        end
      end else begin
        vram_ack = 1'b0; in_wait = 1'b0;
      end
      #1;
      now_pack = {out_hdr, out_vert, out_widx, out_first, out_last, out_data};
      if (mon_en) begin
        if (prev_rd_wait) begin
          checkOutput("rd_held", 64'(vram_rd), 64'd1);
          checkOutput("addr_stable", 64'(vram_addr), 64'(prev_addr));
        end
        if (vram_rd && vram_ack) begin
          rd_count++;
          if (exp_rd.size() == 0) checkOutput("read_queue_empty", 64'(vram_addr), 64'hFFFF_FFFF);
          else checkOutput("read_addr", 64'(vram_addr), 64'(exp_rd.pop_front()));
        end
        if (prev_stall) begin
          checkOutput("hold_valid", 64'(out_valid), 64'd1);
          checkOutput("hold_word", 64'(now_pack), 64'(prev_pack));
        end
        if (out_valid && out_ready) begin
          word_count++;
          if (exp_out.size() == 0) checkOutput("stream_queue_empty", 64'(now_pack), 64'h1_FFFF_FFFF_FFFF);
          else begin
            e = exp_out.pop_front();
            checkOutput("stream_word", 64'(now_pack), 64'(e));
          end
        end
        if (poly_done) done_count++;
        prev_rd_wait = vram_rd && !vram_ack;
        prev_addr    = vram_addr;
        prev_stall   = out_valid && !out_ready;
        prev_pack    = now_pack;
      end else begin
        prev_rd_wait = 1'b0;
        prev_stall   = 1'b0;
      end
    end
  end

  task automatic waitDone(input int budget);
    int c;
    c = 0;
    while (done_count == 0 && c < budget) begin
      @(negedge clock); #3;
      c++;
    end
    if (done_count == 0) checkOutput("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic applyStimulus(input logic [31:0] opb, input logic [23:0] pa, input bit rnd,
                               input int exp_reads, input int exp_words, input bit poke);
    buildModel(opb, pa);
    rand_mode = rnd; rd_count = 0; word_count = 0; done_count = 0; mon_en = 1'b1;
    @(negedge clock);
    opb_word = opb; poly_addr = pa; render_poly = 1'b1;
    @(negedge clock);
    render_poly = 1'b0; opb_word = 32'h4000_0000; poly_addr = 24'h00FF00;
    #3;
    checkOutput("busy_after_start", 64'(busy), 64'd1);
    if (poke) begin
      repeat (3) @(negedge clock);
      render_poly = 1'b1;
      @(negedge clock);
      render_poly = 1'b0;
    end
    waitDone(4000);
    repeat (3) @(negedge clock);
    #3;
    checkOutput("read_count", 64'(rd_count), 64'(exp_reads));
    checkOutput("word_count", 64'(word_count), 64'(exp_words));
    checkOutput("done_pulses", 64'(done_count), 64'd1);
    checkOutput("busy_after_done", 64'(busy), 64'd0);
    checkOutput("reads_left", 64'(exp_rd.size()), 64'd0);
    checkOutput("words_left", 64'(exp_out.size()), 64'd0);
    rand_mode = 1'b0;
  endtask

  initial begin : watchdog
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int c;
    reset_n = 1'b0; render_poly = 1'b0; opb_word = '0; poly_addr = '0;
    #1;
    checkOutput("reset_outs", 64'({vram_rd, vram_addr, out_valid, out_data, out_hdr, out_vert,
                                   out_widx, out_first, out_last, busy, poly_done}), 64'd0);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;

    // Model pins: hand-derived sizes and addresses.
    buildModel(32'h8020_0000, 24'h000100);
    checkOutput("model_s1_reads", 64'(exp_rd.size()), 64'd15);
    checkOutput("model_s1_last", 64'(exp_rd[14]), 64'h138);
    buildModel(32'h5000_0000, 24'h000400);
    checkOutput("model_s2_reads", 64'(exp_rd.size()), 64'd21);
    checkOutput("model_s2_words", 64'(exp_out.size()), 64'd24);
    checkOutput("model_s2_tri2", 64'(exp_rd[12]), 64'h424);
    buildModel(32'hA340_0000, 24'h002000);
    checkOutput("model_s3_reads", 64'(exp_rd.size()), 64'd66);
    checkOutput("model_s3_prim1", 64'(exp_rd[33]), 64'h2084);
    checkOutput("model_s3_vert3", 64'(exp_out[32]), 64'(pk(1'b0, 2'd3, 4'd6, 1'b0, 1'b1, mem_word(24'h2080))));

    $display("[TB] triangle array, 1 prim");
    applyStimulus(32'h8020_0000, 24'h000100, 1'b0, 15, 15, 1'b1);
    $display("[TB] strip, triangles 0 and 2");
    applyStimulus(32'h5000_0000, 24'h000400, 1'b0, 21, 24, 1'b0);
    $display("[TB] quad array, 2 prims, shadow");
    applyStimulus(32'hA340_0000, 24'h002000, 1'b0, 66, 66, 1'b0);
    $display("[TB] random waits and ready");
    applyStimulus(32'hA340_0000, 24'h002000, 1'b1, 66, 66, 1'b0);
    applyStimulus(32'h5000_0000, 24'h000400, 1'b1, 21, 24, 1'b0);

    $display("[TB] reset mid-fetch");
    buildModel(32'hA340_0000, 24'h002000);
    rand_mode = 1'b1; rd_count = 0; word_count = 0; done_count = 0; mon_en = 1'b1;
    @(negedge clock);
    opb_word = 32'hA340_0000; poly_addr = 24'h002000; render_poly = 1'b1;
    @(negedge clock);
    render_poly = 1'b0;
    c = 0;
    while (rd_count < 12 && c < 2000) begin
      @(negedge clock); #3;
      c++;
    end
    checkOutput("reached_mid_vertex", 64'(rd_count >= 12), 64'd1);
    #1;
    mon_en = 1'b0;
    reset_n = 1'b0;
    #1;
    checkOutput("abort_outs", 64'({vram_rd, vram_addr, out_valid, out_data, out_hdr, out_vert,
                                   out_widx, out_first, out_last, busy, poly_done}), 64'd0);
    checkOutput("abort_no_done", 64'(done_count), 64'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    rand_mode = 1'b0; done_count = 0; mon_en = 1'b1;
    repeat (4) @(negedge clock);
    #3;
    checkOutput("no_done_after_abort", 64'(done_count), 64'd0);
    applyStimulus(32'hA340_0000, 24'h002000, 1'b0, 66, 66, 1'b0);

    $display("[TB] invalid type");
    buildModel(32'hE000_0000, 24'h003000);
    rd_count = 0; done_count = 0;
    @(negedge clock);
    opb_word = 32'hE000_0000; poly_addr = 24'h003000; render_poly = 1'b1;
    @(negedge clock); #3;
    checkOutput("invalid_done", 64'(poly_done), 64'd1);
    checkOutput("invalid_no_rd", 64'(vram_rd), 64'd0);
    @(negedge clock);
    render_poly = 1'b0;
    #3;
    checkOutput("start_on_done_ignored", 64'(poly_done), 64'd0);
    repeat (3) @(negedge clock);
    #3;
    checkOutput("invalid_reads", 64'(rd_count), 64'd0);
    checkOutput("invalid_done_pulses", 64'(done_count), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
